fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter NOP_INSTR, default 32'h00000013, the instruction presented when the IF/ID slot is empty.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h00000000, the reset value of pc_id_o and pc_plus_4_id_o.
REQ-003 clk  input  1  the single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 pc_if_i  input  32  current fetch PC from the PC register.
REQ-006 pc_plus_4_if_i  input  32  pc_if_i+4 from the PC register.
REQ-007 flush_if_i  input  1  redirect or flush from branch/jump resolution.
REQ-008 stall_id_i  input  1  decode cannot accept a new instruction.
REQ-009 imem_req_o  output  1  instruction memory request valid.
REQ-010 imem_addr_o  output  32  request address.
REQ-011 imem_gnt_i  input  1  request accepted this cycle.
REQ-012 imem_rvalid_i  input  1  response data valid.
REQ-013 imem_rdata_i  input  32  response instruction word.
REQ-014 fetch_stall_o  output  1  drives the PC register's stall input; low means PC may update this cycle.
REQ-015 valid_id_o, instr_id_o, pc_id_o, pc_plus_4_id_o  output  1/32/32/32  IF/ID register contents.

Function
REQ-016 The FSM SHALL have four states: IDLE, WAIT, HOLD and DROP.
REQ-017 imem_req_o SHALL be (state==IDLE && !flush_if_i); imem_addr_o SHALL equal pc_if_i combinationally.
REQ-018 IDLE with imem_req_o && imem_gnt_i SHALL capture pc_if_i/pc_plus_4_if_i into req_pc/req_pc4 and go to WAIT; without a grant the FSM SHALL stay in IDLE.
REQ-019 WAIT with rvalid, !stall_id_i, !flush SHALL load the IF/ID register with {1, rdata, req_pc, req_pc4} and go to IDLE. This is the "accept" event.
REQ-020 WAIT with rvalid, stall_id_i, !flush SHALL store rdata in a one-entry hold buffer and go to HOLD.
REQ-021 HOLD with !stall_id_i && !flush SHALL move the held word into IF/ID, go to IDLE, and count as an accept.
REQ-022 WAIT without rvalid and with flush SHALL go to DROP. DROP SHALL discard the next rvalid and then go to IDLE.
REQ-023 WAIT or DROP with flush and rvalid in the same cycle SHALL discard the word and go to IDLE. HOLD with flush SHALL discard the buffer and go to IDLE.
REQ-024 fetch_stall_o SHALL be !(flush_if_i || accept), so the PC advances exactly once per delivered instruction and always on redirect.
REQ-025 Flush SHALL take priority over stall_id_i. A flush SHALL set valid_id_o=0 and instr_id_o=NOP_INSTR at the next edge.
REQ-026 With stall_id_i=1 and no flush, the IF/ID outputs SHALL hold their values.
REQ-027 With no accept, no stall and no flush, the IF/ID register SHALL load a bubble: valid 0, instr NOP_INSTR, PCs unchanged.
REQ-028 Latency SHALL be 1 cycle from the rvalid edge to IF/ID output. Minimum throughput SHALL be one instruction per 2 cycles with zero-wait memory (gnt in IDLE, rvalid the next cycle).
REQ-029 All PC arithmetic SHALL be 32-bit, wrap modulo 2^32, and use the incoming values only (no internal adder).

Reset
REQ-030 While rst_n=0 at an edge: state=IDLE, valid_id_o=0, instr_id_o=NOP_INSTR, pc_id_o=RESET_PC, pc_plus_4_id_o=RESET_PC+4, hold buffer cleared.
REQ-031 imem_req_o SHALL be 0 during reset; a reset in WAIT SHALL abandon the outstanding response, and memory responses arriving after reset SHALL be ignored until a new grant.
REQ-032 fetch_stall_o SHALL be 1 during reset unless flush_if_i=1.

Structure
REQ-033 NOP_INSTR, RESET_PC and the FSM state encodings SHALL live in the shared defines.v, alongside the PC_SEL_* codes.
REQ-034 The IF/ID register (load, hold, bubble, flush priority) SHALL be one sub-module, if_id_reg; the FSM and hold buffer SHALL stay in fetch_unit.

Verification
REQ-035 Zero-wait memory, pc sequence 0x0,0x4,0x8 -> IF/ID shows (0x0,0x00500093), (0x4,...), (0x8,...) with valid=1, and fetch_stall_o low once per instruction.
REQ-036 gnt at pc=0x10, rvalid 3 cycles later -> fetch_stall_o held 1 for 3 cycles, then instr at pc_id_o=0x10, pc_plus_4_id_o=0x14.
REQ-037 rvalid arrives while stall_id_i=1 for 2 cycles -> FSM in HOLD, outputs unchanged, word delivered the cycle after stall_id_i falls.
REQ-038 flush in WAIT, rvalid 2 cycles later with 0xDEADBEEF -> word never reaches IF/ID, valid_id_o=0, next request uses the redirected pc_if_i=0x100.
REQ-039 flush and stall_id_i together -> valid_id_o=0, instr_id_o=0x00000013.
REQ-040 rst_n=0 for one edge mid-WAIT -> all outputs at reset values; a late rvalid is ignored and fetch restarts at pc_if_i.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: reset constants, FSM states, PC select codes, IF/ID payload.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF  = 32'h0000_0000;

    // Fetch FSM states
    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_WAIT = 2'd1,
        FS_HOLD = 2'd2,
        FS_DROP = 2'd3
    } fetch_state_e;

    // Next-PC source codes used by the PC register
    typedef enum logic [1:0] {
        PC_SEL_PLUS4  = 2'd0,
        PC_SEL_BRANCH = 2'd1,
        PC_SEL_JALR   = 2'd2,
        PC_SEL_TRAP   = 2'd3
    } pc_sel_e;

    // IF/ID pipeline register payload
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall holds, load on accept, bubble otherwise.
module if_id_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   stall,
    input  logic   load,
    input  if_id_t load_data,
    output if_id_t q
);

    // Register update with flush > stall > load > bubble priority; PCs only change on load
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
            q.pc    <= RESET_PC;
            q.pc4   <= RESET_PC + 32'd4;
        end else if (flush) begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
        end else if (stall) begin
            q <= q;
        end else if (load) begin
            q <= load_data;
        end else begin
            q.valid <= 1'b0;
            q.instr <= NOP_INSTR;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, one-entry hold buffer, IF/ID register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_if_i,
    input  logic [XLEN-1:0] pc_plus_4_if_i,
    input  logic            flush_if_i,
    input  logic            stall_id_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [XLEN-1:0] imem_rdata_i,
    output logic            fetch_stall_o,
    output logic            valid_id_o,
    output logic [XLEN-1:0] instr_id_o,
    output logic [XLEN-1:0] pc_id_o,
    output logic [XLEN-1:0] pc_plus_4_id_o
);

    fetch_state_e    state;
    logic [XLEN-1:0] req_pc;
    logic [XLEN-1:0] req_pc4;
    logic [XLEN-1:0] hold_instr;
    logic            accept;
    if_id_t          load_data;
    if_id_t          if_id_q;

    // Request, accept and PC-stall decode; all gated off while reset is asserted
    always_comb begin
        imem_req_o    = rst_n && (state == FS_IDLE) && !flush_if_i;
        imem_addr_o   = pc_if_i;
        accept        = rst_n && !flush_if_i && !stall_id_i &&
                        (((state == FS_WAIT) && imem_rvalid_i) || (state == FS_HOLD));
        fetch_stall_o = !(flush_if_i || accept);
        load_data.valid = 1'b1;
        load_data.instr = (state == FS_HOLD) ? hold_instr : imem_rdata_i;
        load_data.pc    = req_pc;
        load_data.pc4   = req_pc4;
    end

    // Fetch FSM: track the outstanding request, park words under stall, drop words after redirect
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= FS_IDLE;
            req_pc     <= RESET_PC;
            req_pc4    <= RESET_PC + 32'd4;
            hold_instr <= '0;
        end else begin
            case (state)
                FS_IDLE: begin
                    if (imem_req_o && imem_gnt_i) begin
                        req_pc  <= pc_if_i;
                        req_pc4 <= pc_plus_4_if_i;
                        state   <= FS_WAIT;
                    end
                end
                FS_WAIT: begin
                    if (imem_rvalid_i) begin
                        if (!flush_if_i && stall_id_i) begin
                            hold_instr <= imem_rdata_i;
                            state      <= FS_HOLD;
                        end else begin
                            state <= FS_IDLE;
                        end
                    end else if (flush_if_i) begin
                        state <= FS_DROP;
                    end
                end
                FS_HOLD: begin
                    if (flush_if_i) begin
                        hold_instr <= '0;
                        state      <= FS_IDLE;
                    end else if (!stall_id_i) begin
                        state <= FS_IDLE;
                    end
                end
                FS_DROP: begin
                    if (imem_rvalid_i) begin
                        state <= FS_IDLE;
                    end
                end
                default: state <= FS_IDLE;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR),
        .RESET_PC  (RESET_PC)
    ) u_if_id_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush_if_i),
        .stall     (stall_id_i),
        .load      (accept),
        .load_data (load_data),
        .q         (if_id_q)
    );

    assign valid_id_o     = if_id_q.valid;
    assign instr_id_o     = if_id_q.instr;
    assign pc_id_o        = if_id_q.pc;
    assign pc_plus_4_id_o = if_id_q.pc4;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table, directed corner sequences, random run against a transaction model.
module tb_fetch_unit;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_if, pc4_if;
    logic        flush, stall_id;
    logic        req;
    logic [31:0] addr;
    logic        gnt, rvalid;
    logic [31:0] rdata;
    logic        fstall;
    logic        valid_id;
    logic [31:0] instr_id, pc_id, pc4_id;

    int checks   = 0;
    int failures = 0;

    // Combinational outputs sampled just before the edge
    logic        c_req, c_stall;
    logic [31:0] c_addr;

    // Transaction-level reference model
    logic        mo_out, mo_disc, mo_held;
    logic [31:0] mo_hword, mo_tpc, mo_tpc4;
    logic        mo_valid;
    logic [31:0] mo_instr, mo_pc, mo_pc4;
    logic        m_req, m_acc, m_stall;
    logic [31:0] m_word;

    typedef struct {
        logic        rst_n;
        logic [31:0] pc;
        logic        flush, stall, gnt, rvalid;
        logic [31:0] rdata;
        logic        e_req, e_stall, e_valid;
        logic [31:0] e_instr, e_pc, e_pc4;
    } vec_t;

    vec_t vt[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_if_i        (pc_if),
        .pc_plus_4_if_i (pc4_if),
        .flush_if_i     (flush),
        .stall_id_i     (stall_id),
        .imem_req_o     (req),
        .imem_addr_o    (addr),
        .imem_gnt_i     (gnt),
        .imem_rvalid_i  (rvalid),
        .imem_rdata_i   (rdata),
        .fetch_stall_o  (fstall),
        .valid_id_o     (valid_id),
        .instr_id_o     (instr_id),
        .pc_id_o        (pc_id),
        .pc_plus_4_id_o (pc4_id)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic [31:0] pc, input logic f, input logic s,
                                input logic g, input logic rv, input logic [31:0] rd,
                                input logic ereq, input logic est, input logic ev,
                                input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] ep4);
        vec_t v;
        v.rst_n = r; v.pc = pc; v.flush = f; v.stall = s; v.gnt = g; v.rvalid = rv; v.rdata = rd;
        v.e_req = ereq; v.e_stall = est; v.e_valid = ev; v.e_instr = ei; v.e_pc = ep; v.e_pc4 = ep4;
        return v;
    endfunction

    // One clock: drive at negedge, sample comb outputs, advance model and DUT at posedge
    task automatic step(input logic r, input logic [31:0] pc, input logic f, input logic s,
                        input logic g, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        rst_n = r; pc_if = pc; pc4_if = pc + 32'd4; flush = f; stall_id = s;
        gnt = g; rvalid = rv; rdata = rd;
        #1;
        c_req = req; c_addr = addr; c_stall = fstall;
        // model: what is deliverable this cycle
        m_req  = r && !mo_out && !mo_held && !f;
        m_word = mo_held ? mo_hword : rd;
        m_acc  = r && !f && !s && (mo_held || (mo_out && !mo_disc && rv));
        m_stall = !(f || m_acc);
        @(posedge clk);
        if (!r) begin
            mo_out = 1'b0; mo_disc = 1'b0; mo_held = 1'b0;
            mo_valid = 1'b0; mo_instr = NOP; mo_pc = RPC; mo_pc4 = RPC + 32'd4;
        end else begin
            if (f) begin
                mo_valid = 1'b0; mo_instr = NOP;
            end else if (s) begin
                mo_valid = mo_valid;
            end else if (m_acc) begin
                mo_valid = 1'b1; mo_instr = m_word; mo_pc = mo_tpc; mo_pc4 = mo_tpc4;
            end else begin
                mo_valid = 1'b0; mo_instr = NOP;
            end
            if (m_req && g) begin
                mo_out = 1'b1; mo_disc = 1'b0; mo_tpc = pc; mo_tpc4 = pc + 32'd4;
            end else if (mo_out) begin
                if (rv) begin
                    mo_out = 1'b0;
                    if (!mo_disc && !f && s) begin
                        mo_held = 1'b1; mo_hword = rd;
                    end
                end else if (f) begin
                    mo_disc = 1'b1;
                end
            end else if (mo_held) begin
                if (f || !s) mo_held = 1'b0;
            end
        end
        #1;
    endtask

    task automatic chk_all(input string n, input logic ereq, input logic est, input logic ev,
                           input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] ep4);
        chk({n, ".req"},   32'(c_req),   32'(ereq));
        chk({n, ".addr"},  c_addr,       pc_if);
        chk({n, ".stall"}, 32'(c_stall), 32'(est));
        chk({n, ".valid"}, 32'(valid_id), 32'(ev));
        chk({n, ".instr"}, instr_id,     ei);
        chk({n, ".pc"},    pc_id,        ep);
        chk({n, ".pc4"},   pc4_id,       ep4);
    endtask

    initial begin
        mo_out = 0; mo_disc = 0; mo_held = 0; mo_hword = 0; mo_tpc = 0; mo_tpc4 = 0;
        mo_valid = 0; mo_instr = NOP; mo_pc = RPC; mo_pc4 = RPC + 32'd4;
        rst_n = 0; pc_if = 0; pc4_if = 4; flush = 0; stall_id = 0; gnt = 0; rvalid = 0; rdata = 0;

        //        rst pc           f  s  g  rv rdata         req st val instr         pc           pc4
        vt.push_back(mk(0, 32'h0,        0, 0, 1, 1, 32'h1234_5678, 0, 1, 0, NOP,          32'h0,        32'h4));
        vt.push_back(mk(1, 32'h0,        0, 0, 1, 0, 32'h0,         1, 1, 0, NOP,          32'h0,        32'h4));
        vt.push_back(mk(1, 32'h0,        0, 0, 0, 1, 32'h0050_0093, 0, 0, 1, 32'h0050_0093, 32'h0,       32'h4));
        vt.push_back(mk(1, 32'h4,        0, 0, 1, 0, 32'h0,         1, 1, 0, NOP,          32'h0,        32'h4));
        vt.push_back(mk(1, 32'h4,        0, 0, 0, 1, 32'h0010_0113, 0, 0, 1, 32'h0010_0113, 32'h4,       32'h8));
        vt.push_back(mk(1, 32'h8,        0, 0, 1, 0, 32'h0,         1, 1, 0, NOP,          32'h4,        32'h8));
        vt.push_back(mk(1, 32'h8,        0, 0, 0, 1, 32'h0020_8193, 0, 0, 1, 32'h0020_8193, 32'h8,       32'hC));
        vt.push_back(mk(1, 32'h10,       0, 0, 1, 0, 32'h0,         1, 1, 0, NOP,          32'h8,        32'hC));
        vt.push_back(mk(1, 32'h10,       0, 0, 0, 0, 32'h0,         0, 1, 0, NOP,          32'h8,        32'hC));
        vt.push_back(mk(1, 32'h10,       0, 0, 0, 0, 32'h0,         0, 1, 0, NOP,          32'h8,        32'hC));
        vt.push_back(mk(1, 32'h10,       0, 0, 0, 1, 32'h00C0_0213, 0, 0, 1, 32'h00C0_0213, 32'h10,      32'h14));
        vt.push_back(mk(1, 32'h14,       1, 1, 0, 0, 32'h0,         0, 0, 0, NOP,          32'h10,       32'h14));
        vt.push_back(mk(1, 32'hFFFF_FFFC,0, 0, 1, 0, 32'h0,         1, 1, 0, NOP,          32'h10,       32'h14));
        vt.push_back(mk(1, 32'hFFFF_FFFC,0, 0, 0, 1, 32'h0000_006F, 0, 0, 1, 32'h0000_006F, 32'hFFFF_FFFC, 32'h0));

        step(0, 32'h0, 0, 0, 0, 0, 32'h0);
        foreach (vt[i]) begin
            step(vt[i].rst_n, vt[i].pc, vt[i].flush, vt[i].stall, vt[i].gnt, vt[i].rvalid, vt[i].rdata);
            chk_all($sformatf("v%0d", i), vt[i].e_req, vt[i].e_stall, vt[i].e_valid,
                    vt[i].e_instr, vt[i].e_pc, vt[i].e_pc4);
        end

        // Word arrives under decode stall, parked, then delivered when stall drops
        step(1, 32'h20, 0, 1, 1, 0, 32'h0);
        chk_all("hold0", 1, 1, 1, 32'h0000_006F, 32'hFFFF_FFFC, 32'h0);
        step(1, 32'h20, 0, 1, 0, 1, 32'h00A0_0293);
        chk_all("hold1", 0, 1, 1, 32'h0000_006F, 32'hFFFF_FFFC, 32'h0);
        step(1, 32'h20, 0, 1, 0, 0, 32'h0);
        chk_all("hold2", 0, 1, 1, 32'h0000_006F, 32'hFFFF_FFFC, 32'h0);
        step(1, 32'h24, 0, 0, 0, 0, 32'h0);
        chk_all("hold3", 0, 0, 1, 32'h00A0_0293, 32'h20, 32'h24);

        // Redirect while waiting: late word dropped, next request at new PC
        step(1, 32'h30, 0, 0, 1, 0, 32'h0);
        chk_all("drop0", 1, 1, 0, NOP, 32'h20, 32'h24);
        step(1, 32'h100, 1, 0, 0, 0, 32'h0);
        chk_all("drop1", 0, 0, 0, NOP, 32'h20, 32'h24);
        step(1, 32'h100, 0, 0, 0, 0, 32'h0);
        chk_all("drop2", 0, 1, 0, NOP, 32'h20, 32'h24);
        step(1, 32'h100, 0, 0, 0, 1, 32'hDEAD_BEEF);
        chk_all("drop3", 0, 1, 0, NOP, 32'h20, 32'h24);
        step(1, 32'h100, 0, 0, 1, 0, 32'h0);
        chk_all("drop4", 1, 1, 0, NOP, 32'h20, 32'h24);
        step(1, 32'h100, 0, 0, 0, 1, 32'h0000_0513);
        chk_all("drop5", 0, 0, 1, 32'h0000_0513, 32'h100, 32'h104);

        // Reset mid-wait: outstanding response abandoned, fetch restarts
        step(1, 32'h200, 0, 0, 1, 0, 32'h0);
        chk_all("rst0", 1, 1, 0, NOP, 32'h100, 32'h104);
        step(0, 32'h200, 0, 0, 0, 0, 32'h0);
        chk_all("rst1", 0, 1, 0, NOP, RPC, RPC + 32'd4);
        step(1, 32'h300, 0, 0, 0, 1, 32'hBAD0_BAD0);
        chk_all("rst2", 1, 1, 0, NOP, RPC, RPC + 32'd4);
        step(1, 32'h300, 0, 0, 1, 0, 32'h0);
        chk_all("rst3", 1, 1, 0, NOP, RPC, RPC + 32'd4);
        step(1, 32'h300, 0, 0, 0, 1, 32'h0000_0593);
        chk_all("rst4", 0, 0, 1, 32'h0000_0593, 32'h300, 32'h304);

        // Random traffic against the transaction model
        for (int n = 0; n < 1500; n++) begin
            logic        r, f, s, g, rv;
            logic [31:0] pc, rd;
            r  = ($urandom_range(39) != 0);
            f  = ($urandom_range(7) == 0);
            s  = ($urandom_range(2) == 0);
            g  = ($urandom_range(1) == 0);
            rv = ($urandom_range(1) == 0);
            pc = $urandom & 32'hFFFF_FFFC;
            rd = $urandom;
            step(r, pc, f, s, g, rv, rd);
            chk_all($sformatf("rnd%0d", n), m_req, m_stall, mo_valid, mo_instr, mo_pc, mo_pc4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
